// File: rtl/ucisc_pkg.sv
// Shared types and constants for the uCISC fetch front end.
// Define FETCH_BUF2_EN for a two-entry fetch buffer (full-rate fetch); default is one entry.
package ucisc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // Widest PC the buffer entry can carry; narrower PCs are zero-extended.
    localparam int          MAX_ADDR_WIDTH   = 32;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

`ifdef FETCH_BUF2_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    typedef struct packed {
        logic [15:0]               instruction;
        logic [MAX_ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: shift FIFO whose head is always slot 0, so the head is a plain register.
// Simultaneous push and pop both take effect; flush empties it and wins over push.
module fetch_buffer
    import ucisc_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               push_entry,
    output fetch_entry_t               head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t entries     [DEPTH];
    fetch_entry_t entries_nxt [DEPTH];
    int           wr_idx;

    always_comb begin
        entries_nxt = entries;
        wr_idx      = int'(occupancy) - int'(pop);
        if (pop)
            for (int i = 1; i < DEPTH; i++) entries_nxt[i-1] = entries[i];
        if (push)
            for (int i = 0; i < DEPTH; i++)
                if (i == wr_idx) entries_nxt[i] = push_entry;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            entries   <= entries_nxt;
            occupancy <= occupancy + CW'(push) - CW'(pop);
        end
    end

    assign head  = entries[0];
    assign empty = (occupancy == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: credit-gated sequential fetch into fetch_buffer, with redirect flush.
// Buffer depth is 1 by default and 2 when FETCH_BUF2_EN is defined.
module instruction_fetch
    import ucisc_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [15:0]           mem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic                  instruction_valid,
    input  logic                  instruction_ready,
    output logic [15:0]           instruction,
    output logic [ADDR_WIDTH-1:0] instruction_pc
);
    localparam int CW = $clog2(FETCH_DEPTH + 1);
    localparam int SW = CW + 1;

    fetch_state_t          state, state_nxt;
    logic [ADDR_WIDTH-1:0] fetch_pc, inflight_pc;
    logic                  inflight, inflight_epoch, epoch;
    logic                  pop, push, credit_ok, issue, buf_empty;
    logic [CW-1:0]         occupancy;
    fetch_entry_t          push_entry, head;
    logic                  unused_head_pc;

    assign instruction_valid = reset_n && !buf_empty;
    assign pop               = instruction_valid && instruction_ready;

    // Held + in-flight words, less this cycle's pop, must leave room for one more.
    assign credit_ok = ({1'b0, occupancy} + SW'(inflight)) < (SW'(FETCH_DEPTH) + SW'(pop));

    // HOLD only records a stall; the request goes out in the very cycle credit returns.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN, HOLD: begin
                issue     = credit_ok && !halt && !redirect_valid;
                state_nxt = (credit_ok && !halt) ? RUN : HOLD;
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign mem_read = reset_n && issue;
    assign mem_addr = reset_n ? fetch_pc : RESET_PC;

    // Responses tagged before a flush carry a stale epoch and are dropped.
    assign push = inflight && (inflight_epoch == epoch) && !redirect_valid;

    always_comb begin
        push_entry             = '0;
        push_entry.instruction = mem_data;
        push_entry.pc          = MAX_ADDR_WIDTH'(inflight_pc);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= BOOT;
            fetch_pc       <= RESET_PC;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= RESET_PC;
            epoch          <= 1'b0;
        end else begin
            state          <= state_nxt;
            inflight       <= issue;
            inflight_epoch <= epoch;
            inflight_pc    <= fetch_pc;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                epoch    <= ~epoch;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
            end
        end
    end

    fetch_buffer #(.DEPTH(FETCH_DEPTH)) u_buf (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_entry (push_entry),
        .head       (head),
        .empty      (buf_empty),
        .occupancy  (occupancy)
    );

    assign instruction    = reset_n ? head.instruction : 16'h0000;
    assign instruction_pc = reset_n ? head.pc[ADDR_WIDTH-1:0] : RESET_PC;
    assign unused_head_pc = ^head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations plus a per-cycle
// stream model (memory word[n] = n + 16'h0100, delivered strictly in PC order).
module tb_instruction_fetch;
    localparam int AW = 16;
`ifdef FETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [AW-1:0] RPC = 16'h0000;

    logic          clock = 1'b0;
    logic          reset_n, mem_read, redirect_valid, halt, instruction_valid, instruction_ready;
    logic [AW-1:0] mem_addr, redirect_pc, instruction_pc;
    logic [15:0]   instruction;
    logic [15:0]   mem_data = 16'hDEAD;
    logic [15:0]   mem_q    = 16'hDEAD;
    int            checks = 0, failures = 0;

    instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .mem_read          (mem_read),
        .mem_addr          (mem_addr),
        .mem_data          (mem_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .halt              (halt),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready),
        .instruction       (instruction),
        .instruction_pc    (instruction_pc)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory: answers a read one cycle later.
    always @(posedge clock) begin
        #1;
        mem_data = mem_q;
    end

    // Stream model: words held + in flight never exceed DEPTH, delivery is in PC order.
    int            held_m = 0, infl_m = 0;
    bit            boot_m = 1'b1;
    logic [AW-1:0] exp_req = RPC, exp_head = RPC;

    always @(negedge clock) begin
        bit exp_valid, hs, exp_mr;
        mem_q = mem_read ? 16'(mem_addr + 16'h0100) : 16'hDEAD;
        if (!reset_n) begin
            check("rst_mem_read", 32'(mem_read), 32'd0);
            check("rst_mem_addr", 32'(mem_addr), 32'(RPC));
            check("rst_valid", 32'(instruction_valid), 32'd0);
            check("rst_instruction", 32'(instruction), 32'd0);
            check("rst_instruction_pc", 32'(instruction_pc), 32'(RPC));
            held_m = 0; infl_m = 0; boot_m = 1'b1; exp_req = RPC; exp_head = RPC;
        end else begin
            exp_valid = held_m > 0;
            hs        = exp_valid && instruction_ready;
            exp_mr    = !boot_m && !halt && !redirect_valid && (held_m + infl_m - int'(hs) < DEPTH);
            check("model_valid", 32'(instruction_valid), 32'(exp_valid));
            check("model_mem_read", 32'(mem_read), 32'(exp_mr));
            if (exp_mr && mem_read) check("model_mem_addr", 32'(mem_addr), 32'(exp_req));
            if (exp_valid && instruction_valid) begin
                check("model_pc", 32'(instruction_pc), 32'(exp_head));
                check("model_instr", 32'(instruction), 32'(16'(exp_head + 16'h0100)));
            end
            if (redirect_valid) begin
                held_m = 0; exp_head = redirect_pc; exp_req = redirect_pc;
            end else begin
                held_m = held_m + infl_m - int'(hs);
                if (hs) exp_head++;
                if (exp_mr) exp_req++;
            end
            infl_m = int'(exp_mr);
            boot_m = 1'b0;
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!mem_read && n < 20) begin nxt(); smp(); n++; end
        check(name, 32'(mem_read), 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instruction_valid && n < 20) begin nxt(); smp(); n++; end
        check(name, 32'(instruction_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    int            hs_cnt, mr_cnt, nv_cnt, k;
    logic [AW-1:0] p0, p1, a_last;
    bit            seen;

    initial begin
        reset_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instruction_ready = 1'b1;
        repeat (3) nxt();

        // Reset release: BOOT, first request at cycle 1, first word at cycle 3.
        reset_n = 1'b1;
        smp(); check("c0_no_req", 32'(mem_read), 32'd0);
        nxt(); smp(); check("c1_req", 32'({mem_read, mem_addr}), 32'({1'b1, 16'h0000}));
        nxt(); smp(); check("c2_not_valid", 32'(instruction_valid), 32'd0);
        nxt(); smp();
        check("c3_valid", 32'(instruction_valid), 32'd1);
        check("c3_instr", 32'(instruction), 32'h0100);
        check("c3_pc", 32'(instruction_pc), 32'h0000);
        hs_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (instruction_valid && instruction_ready) hs_cnt++;
            nxt(); smp();
        end
        check("throughput_10cyc", 32'(hs_cnt), (DEPTH == 2) ? 32'd10 : 32'd5);

        // Decoder stall for 5 cycles.
        nxt(); instruction_ready = 1'b0;
        mr_cnt = 0; nv_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            smp();
            if (i >= 2 && mem_read) mr_cnt++;
            if (i >= 2 && !instruction_valid) nv_cnt++;
            nxt();
        end
        instruction_ready = 1'b1;
        smp();
        check("stall_no_req", 32'(mr_cnt), 32'd0);
        check("stall_valid_held", 32'(nv_cnt), 32'd0);
        repeat (6) begin nxt(); smp(); end

        // Redirect with a request in flight.
        wait_req("redir_pre_req");
        nxt(); redirect_valid = 1'b1; redirect_pc = 16'h0040; smp();
        nxt(); redirect_valid = 1'b0; smp();
        check("redir_first_req", 32'({mem_read, mem_addr}), 32'({1'b1, 16'h0040}));
        wait_valid("redir_valid");
        check("redir_first_pc", 32'(instruction_pc), 32'h0040);
        repeat (4) begin nxt(); smp(); end

        // PC wrap FFFF -> 0000.
        nxt(); redirect_valid = 1'b1; redirect_pc = 16'hFFFF; smp();
        nxt(); redirect_valid = 1'b0; smp();
        check("wrap_req0", 32'({mem_read, mem_addr}), 32'({1'b1, 16'hFFFF}));
        nxt(); smp();
        wait_req("wrap_req1_seen");
        check("wrap_req1", 32'(mem_addr), 32'h0000);
        k = 0; p0 = '1; p1 = '1;
        for (int n = 0; n < 20 && k < 2; n++) begin
            if (instruction_valid && instruction_ready) begin
                if (k == 0) p0 = instruction_pc; else p1 = instruction_pc;
                k++;
            end
            if (k < 2) begin nxt(); smp(); end
        end
        check("wrap_hs_count", 32'(k), 32'd2);
        check("wrap_pc0", 32'(p0), 32'hFFFF);
        check("wrap_pc1", 32'(p1), 32'h0000);
        repeat (3) begin nxt(); smp(); end

        // Halt for 3 cycles with one word in flight.
        wait_req("halt_pre_req");
        a_last = mem_addr;
        nxt(); halt = 1'b1; seen = 1'b0; mr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            smp();
            if (mem_read) mr_cnt++;
            if (instruction_valid && instruction_pc == a_last) seen = 1'b1;
            nxt();
        end
        halt = 1'b0;
        smp();
        check("halt_no_req", 32'(mr_cnt), 32'd0);
        check("halt_word_captured", 32'(seen), 32'd1);
        wait_req("halt_resume_seen");
        check("halt_resume_addr", 32'(mem_addr), 32'(16'(a_last + 16'd1)));
        repeat (3) begin nxt(); smp(); end

        // Reset mid-stream.
        wait_req("rst_pre_req");
        nxt(); reset_n = 1'b0; smp();
        nxt(); reset_n = 1'b1; smp();
        check("rel_c0_valid", 32'(instruction_valid), 32'd0);
        check("rel_c0_req", 32'(mem_read), 32'd0);
        nxt(); smp();
        check("rel_c1_req", 32'({mem_read, mem_addr}), 32'({1'b1, RPC}));
        check("rel_c1_valid", 32'(instruction_valid), 32'd0);
        nxt(); smp(); check("rel_c2_valid", 32'(instruction_valid), 32'd0);
        nxt(); smp(); check("rel_c3_head", 32'({instruction_valid, instruction_pc}), 32'({1'b1, RPC}));
        repeat (4) begin nxt(); smp(); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
